// File: rtl/alu_8_bit.sv
// 8-bit ALU with a single registered output stage and synchronous active-low reset.
// Define ALU_8_BIT_FLAGS_EN to add registered carry and zero flag outputs.
module alu_8_bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [1:0] S1,
    input  logic [2:0] S2,
    input  logic [3:0] S3,
`ifdef ALU_8_BIT_FLAGS_EN
    output logic       carry,
    output logic       zero,
`endif
    output logic [7:0] O
);

    logic [7:0] w_result;
    logic [7:0] r_o;

    always_comb begin
        w_result = 8'h00;
        case (S1)
            2'b00: begin
                case (S2)
                    3'b000:  w_result = A + B;
                    3'b001:  w_result = A - B;
                    3'b010:  w_result = A + 8'd1;
                    3'b011:  w_result = A - 8'd1;
                    3'b100:  w_result = B + 8'd1;
                    3'b101:  w_result = B - 8'd1;
                    3'b110:  w_result = A * B;
                    default: w_result = 8'h00 - A;
                endcase
            end
            2'b01: begin
                case (S3)
                    4'b0000: w_result = A & B;
                    4'b0001: w_result = A | B;
                    4'b0010: w_result = A ^ B;
                    4'b0011: w_result = ~(A & B);
                    4'b0100: w_result = ~(A | B);
                    4'b0101: w_result = ~(A ^ B);
                    4'b0110: w_result = ~A;
                    4'b0111: w_result = ~B;
                    4'b1000: w_result = {A[6:0], 1'b0};
                    4'b1001: w_result = {1'b0, A[7:1]};
                    4'b1010: w_result = {A[6:0], A[7]};
                    4'b1011: w_result = {A[0], A[7:1]};
                    4'b1100: w_result = {7'd0, (A > B)};
                    4'b1101: w_result = {7'd0, (A == B)};
                    4'b1110: w_result = A;
                    default: w_result = B;
                endcase
            end
            2'b10:   w_result = A;
            default: w_result = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_o <= 8'h00;
        end else begin
            r_o <= w_result;
        end
    end

    assign O = r_o;

`ifdef ALU_8_BIT_FLAGS_EN
    logic [8:0] w_add_ab;
    logic       w_carry;
    logic       r_carry;
    logic       r_zero;

    assign w_add_ab = {1'b0, A} + {1'b0, B};

    // Subtract/decrement ops report borrow; shifts and rotates report the bit moved out.
    always_comb begin
        w_carry = 1'b0;
        if (S1 == 2'b00) begin
            case (S2)
                3'b000:  w_carry = w_add_ab[8];
                3'b001:  w_carry = (A < B);
                3'b010:  w_carry = (A == 8'hFF);
                3'b011:  w_carry = (A == 8'h00);
                3'b100:  w_carry = (B == 8'hFF);
                3'b101:  w_carry = (B == 8'h00);
                default: w_carry = 1'b0;
            endcase
        end else if (S1 == 2'b01) begin
            case (S3)
                4'b1000: w_carry = A[7];
                4'b1001: w_carry = A[0];
                4'b1010: w_carry = A[7];
                4'b1011: w_carry = A[0];
                default: w_carry = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_carry <= w_carry;
            r_zero  <= (w_result == 8'h00);
        end
    end

    assign carry = r_carry;
    assign zero  = r_zero;
`endif

endmodule

// File: tb/tb_alu_8_bit.sv
// Scoreboard bench for alu_8_bit: driver queues expected results, monitor checks O each cycle.
// Flag checks are active when ALU_8_BIT_FLAGS_EN is defined.
module tb_alu_8_bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] A;
    logic [7:0] B;
    logic [1:0] S1;
    logic [2:0] S2;
    logic [3:0] S3;
    logic [7:0] O;
`ifdef ALU_8_BIT_FLAGS_EN
    logic       carry;
    logic       zero;
`endif

    alu_8_bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .S1    (S1),
        .S2    (S2),
        .S3    (S3),
`ifdef ALU_8_BIT_FLAGS_EN
        .carry (carry),
        .zero  (zero),
`endif
        .O     (O)
    );

    typedef struct {
        logic [7:0] o;
        logic       c;
        logic       z;
        string      name;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model straight from the opcode table, using integer arithmetic mod 256.
    function automatic exp_t model(input bit in_rst, input int a, input int b,
                                   input int s1, input int s2, input int s3);
        exp_t m;
        int   r;
        bit   c;
        r = 0;
        c = 1'b0;
        case (s1)
            0: case (s2)
                0: begin r = a + b; c = (r > 255); end
                1: begin r = a - b; c = (a < b); end
                2: begin r = a + 1; c = (r > 255); end
                3: begin r = a - 1; c = (a < 1); end
                4: begin r = b + 1; c = (r > 255); end
                5: begin r = b - 1; c = (b < 1); end
                6: r = a * b;
                default: r = 0 - a;
            endcase
            1: case (s3)
                0:  r = a & b;
                1:  r = a | b;
                2:  r = a ^ b;
                3:  r = 255 - (a & b);
                4:  r = 255 - (a | b);
                5:  r = 255 - (a ^ b);
                6:  r = 255 - a;
                7:  r = 255 - b;
                8:  begin r = a * 2; c = (a >= 128); end
                9:  begin r = a / 2; c = (a % 2 == 1); end
                10: begin r = a * 2 + a / 128; c = (a >= 128); end
                11: begin r = a / 2 + (a % 2) * 128; c = (a % 2 == 1); end
                12: r = (a > b) ? 1 : 0;
                13: r = (a == b) ? 1 : 0;
                14: r = a;
                default: r = b;
            endcase
            2: r = a;
            default: r = 0;
        endcase
        r = ((r % 256) + 256) % 256;
        if (in_rst) begin
            m.o = 8'h00;
            m.c = 1'b0;
            m.z = 1'b0;
        end else begin
            m.o = 8'(r);
            m.c = c;
            m.z = (r == 0);
        end
        return m;
    endfunction

    // Applies one cycle of stimulus and queues its expected response.
    task automatic drive(input bit in_rst, input int a, input int b, input int s1,
                         input int s2, input int s3, input string name,
                         input bit use_lit, input logic [7:0] lit);
        exp_t e;
        rst_n = ~in_rst;
        A  = 8'(a);
        B  = 8'(b);
        S1 = 2'(s1);
        S2 = 3'(s2);
        S3 = 4'(s3);
        e = model(in_rst, a, b, s1, s2, s3);
        if (use_lit) e.o = lit;
        e.name = name;
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (O !== e.o) begin
                    errors++;
                    $display("FAIL %s: O=%h required %h", e.name, O, e.o);
                end
`ifdef ALU_8_BIT_FLAGS_EN
                checks++;
                if (carry !== e.c) begin
                    errors++;
                    $display("FAIL %s carry: got %b required %b", e.name, carry, e.c);
                end
                checks++;
                if (zero !== e.z) begin
                    errors++;
                    $display("FAIL %s zero: got %b required %b", e.name, zero, e.z);
                end
`endif
            end
        end
    end

    initial begin : driver
        int a, b, s1;
        drive(1, 7, 4, 0, 0, 0, "reset0", 1, 8'h00);
        drive(1, 7, 4, 0, 0, 0, "reset1", 1, 8'h00);
        drive(0, 7, 4, 0, 0, 0, "release_add", 1, 8'h0B);

        drive(0, 7, 4, 0, 1, 5,  "sub",  1, 8'h03);
        drive(0, 7, 4, 0, 2, 9,  "inc_a", 1, 8'h08);
        drive(0, 7, 4, 0, 3, 0,  "dec_a", 1, 8'h06);
        drive(0, 7, 4, 0, 4, 3,  "inc_b", 1, 8'h05);
        drive(0, 7, 4, 0, 5, 12, "dec_b", 1, 8'h03);
        drive(0, 7, 4, 0, 6, 1,  "mul",  1, 8'h1C);
        drive(0, 7, 4, 0, 7, 15, "neg",  1, 8'hF9);

        drive(0, 7, 4, 1, 3, 0,  "and",  1, 8'h04);
        drive(0, 7, 4, 1, 0, 1,  "or",   1, 8'h07);
        drive(0, 7, 4, 1, 6, 2,  "xor",  1, 8'h03);
        drive(0, 7, 4, 1, 1, 3,  "nand", 1, 8'hFB);
        drive(0, 7, 4, 1, 2, 4,  "nor",  1, 8'hF8);
        drive(0, 7, 4, 1, 7, 5,  "xnor", 1, 8'hFC);
        drive(0, 7, 4, 1, 4, 6,  "not_a", 1, 8'hF8);
        drive(0, 7, 4, 1, 5, 7,  "not_b", 1, 8'hFB);
        drive(0, 7, 4, 1, 0, 8,  "shl",  1, 8'h0E);
        drive(0, 7, 4, 1, 0, 9,  "shr",  1, 8'h03);
        drive(0, 8'h81, 4, 1, 0, 10, "rol", 1, 8'h03);
        drive(0, 7, 4, 1, 0, 11, "ror",  1, 8'h83);
        drive(0, 7, 4, 1, 0, 12, "gt",   1, 8'h01);
        drive(0, 4, 7, 1, 0, 12, "gt_false", 1, 8'h00);
        drive(0, 7, 4, 1, 0, 13, "eq_false", 1, 8'h00);
        drive(0, 4, 4, 1, 0, 13, "eq_true", 1, 8'h01);
        drive(0, 7, 4, 1, 0, 14, "pass_a3", 1, 8'h07);
        drive(0, 7, 4, 1, 0, 15, "pass_b3", 1, 8'h04);

        drive(0, 8'hFF, 1, 0, 0, 0, "wrap_add", 1, 8'h00);
        drive(0, 3, 4, 0, 1, 0,     "wrap_sub", 1, 8'hFF);
        drive(0, 8'hFF, 0, 0, 2, 0, "wrap_inc", 1, 8'h00);
        drive(0, 0, 0, 0, 3, 0,     "wrap_dec", 1, 8'hFF);

        drive(0, 8'h5A, 3, 2, 6, 13, "sel_pass_a", 1, 8'h5A);
        drive(0, 8'h5A, 3, 3, 0, 14, "sel_zero",   1, 8'h00);

        drive(0, 9, 9, 0, 0, 0, "pre_reset", 1, 8'h12);
        drive(1, 9, 9, 0, 0, 0, "mid_reset", 1, 8'h00);
        drive(0, 9, 9, 0, 0, 0, "post_reset", 1, 8'h12);

        for (int i = 0; i < 400; i++) begin
            a  = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 255)
                                             : int'($urandom_range(0, 255));
            b  = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 255)
                                             : int'($urandom_range(0, 255));
            s1 = ($urandom_range(0, 9) < 4) ? 0 : (($urandom_range(0, 9) < 8) ? 1
                                                   : int'($urandom_range(2, 3)));
            drive(($urandom_range(0, 19) == 0), a, b, s1,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                  "random", 0, 8'h00);
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: pending=%0d required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
